// File: rtl/bit_serial_add_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial adder. Operands are added LSB-first
// with a registered carry, and the sum comes back in parallel, tagged with the owner's index.
module bit_serial_add_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_carry
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [WIDTH-1:0]     resp_sum_q, resp_sum_d;
  logic                 carry_q, carry_d;
  logic                 resp_carry_q, resp_carry_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [2*NUM_REQ-1:0] rot;
  logic [ID_W-1:0]      grant;
  logic                 grant_found;
  logic                 sum_bit;
  logic                 carry_out;
  logic [WIDTH-1:0]     sum_next;

  // Rotate the valids so the pointer sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    rot         = {req_valid, req_valid} >> ptr_q;
    grant       = '0;
    grant_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_found = 1'b1;
        grant = (int'(ptr_q) + k >= NUM_REQ) ? ID_W'(int'(ptr_q) + k - NUM_REQ)
                                             : ID_W'(int'(ptr_q) + k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && !reset && grant_found && (grant == ID_W'(i));
    end
  end

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_next  = {sum_bit, sum_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = req_a[int'(grant)*WIDTH +: WIDTH];
          b_d     = req_b[int'(grant)*WIDTH +: WIDTH];
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          id_d    = grant;
          ptr_d   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_next;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          resp_sum_d   = sum_next;
          resp_carry_d = carry_out;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;

endmodule
